// File: rtl/pf_pkg.sv
// Shared types and constants for the prefetch queue and its in-flight tracker.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pf_pkg;

  // Default address width; prefetch_queue ADDR_W is expected to match it so
  // that queue entries and the invalid marker line up with the ports.
  localparam int PF_ADDR_W = 16;

  // All-ones address is the prefetcher's "no request" marker.
  localparam logic [PF_ADDR_W-1:0] ADDR_INVALID = '1;

  // Saturation limit of the drop counter.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  // One prefetch queue slot.
  typedef struct packed {
    logic                 valid;
    logic                 cancelled;
    logic [PF_ADDR_W-1:0] addr;
  } pf_entry_t;

  // Saturating 8-bit increment used by the drop counter.
  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pf_inflight_fifo.sv
// In-flight prefetch tracker: in-order address FIFO with a parallel probe match.
// Latency: push/pop visible in count and match the cycle after the edge.
// Backpressure: none internally; push is ignored when full (caller never pushes when full), pop on empty is ignored.
module pf_inflight_fifo
  import pf_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          pushAddr,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          probeAddr,
  output logic                       probeMatch,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DEPTH-1:0]  slotValid;
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     wrPtr;
  logic              doPush;
  logic              doPop;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Qualify push/pop against current occupancy.
  always_comb begin
    doPop  = pop && (count != '0);
    doPush = push && ((count != CW'(DEPTH)) || doPop);
  end

  // Pointer, occupancy and per-slot valid bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      slotValid <= '0;
    end else begin
      if (doPop) begin
        slotValid[rdPtr] <= 1'b0;
        rdPtr            <= nextPtr(rdPtr);
      end
      if (doPush) begin
        slotValid[wrPtr] <= 1'b1;
        wrPtr            <= nextPtr(wrPtr);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Address storage; slotValid gates every read so no reset is needed here.
  always_ff @(posedge clk) begin
    if (doPush) addrMem[wrPtr] <= pushAddr;
  end

  // Parallel compare of the probe against every live slot.
  always_comb begin
    probeMatch = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotValid[i] && (addrMem[i] == probeAddr)) probeMatch = 1'b1;
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch request queue with dedup, demand cancel and an in-flight limit.
// Latency: 1 cycle from accepted request to mem_req_valid on an empty queue; one issue per cycle sustained.
// Backpressure: mem_req_ready low holds head stable; full queue or MAX_OUT in flight rejects/stalls, counted in drop_count.
module prefetch_queue
  import pf_pkg::*;
#(
  parameter int ADDR_W  = PF_ADDR_W,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic                         demand_valid,
  input  logic [ADDR_W-1:0]            demand_addr,
  output logic                         mem_req_valid,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  output logic                         full,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic [7:0]                   drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  pf_entry_t     queue [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] occupancy;
  logic [7:0]    dropCnt;

  pf_entry_t     headEntry;
  logic [OW-1:0] inflightCount;
  logic          inflightMatch;
  logic          issueSlotFree;
  logic          issueFire;
  logic          skipHead;
  logic          popHead;
  logic          queueDup;
  logic          demandHit;
  logic          reqLive;
  logic          enqueue;
  logic          dropReq;
  logic          respPop;

  // Head view and issue decision, from registered state only.
  always_comb begin
    headEntry     = queue[headPtr];
    issueSlotFree = (inflightCount < OW'(MAX_OUT));
    mem_req_valid = headEntry.valid && !headEntry.cancelled && issueSlotFree;
    mem_req_addr  = mem_req_valid ? headEntry.addr : '0;
    issueFire     = mem_req_valid && mem_req_ready;
    // Cancelled heads are discarded without touching the memory port.
    skipHead      = headEntry.valid && headEntry.cancelled;
    popHead       = issueFire || skipHead;
    respPop       = mem_resp_valid;
  end

  // Duplicate scan against live (non-cancelled) queue entries.
  always_comb begin
    queueDup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (queue[i].valid && !queue[i].cancelled && (queue[i].addr == req_addr)) queueDup = 1'b1;
    end
  end

  // Accept/drop decision; fullness uses last-edge occupancy, no bypass.
  always_comb begin
    demandHit = demand_valid && (demand_addr == req_addr);
    reqLive   = req_valid && (req_addr != ADDR_INVALID);
    enqueue   = reqLive && !full && !queueDup && !inflightMatch && !demandHit;
    dropReq   = reqLive && !enqueue;
  end

  // Queue slots: demand cancel, head retire and tail write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) queue[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (demand_valid && queue[i].valid && (queue[i].addr == demand_addr)) begin
          queue[i].cancelled <= 1'b1;
        end
      end
      if (popHead) queue[headPtr].valid <= 1'b0;
      // A matching demand forces a drop, so the tail write never races a cancel.
      if (enqueue) queue[tailPtr] <= '{valid: 1'b1, cancelled: 1'b0, addr: req_addr};
    end
  end

  // Ring pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      occupancy <= '0;
    end else begin
      if (popHead) headPtr <= headPtr + PW'(1);
      if (enqueue) tailPtr <= tailPtr + PW'(1);
      case ({enqueue, popHead})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Saturating count of rejected requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dropCnt <= '0;
    else if (dropReq) dropCnt <= satInc8(dropCnt);
  end

  // In-order in-flight tracker; also answers the dedup probe for req_addr.
  pf_inflight_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (MAX_OUT)
  ) u_inflight (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (issueFire),
    .pushAddr   (headEntry.addr),
    .pop        (respPop),
    .probeAddr  (req_addr),
    .probeMatch (inflightMatch),
    .count      (inflightCount)
  );

  // Status outputs reflect state after the last edge.
  always_comb begin
    full        = (occupancy == CW'(DEPTH));
    outstanding = inflightCount;
    drop_count  = dropCnt;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue.
// Latency: inputs driven 1ns after posedge, outputs sampled there (state after last edge).
// Backpressure: exercised via mem_req_ready stalls and the MAX_OUT limit.
module tb_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        demand_valid;
  logic [15:0] demand_addr;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic        full;
  logic [2:0]  outstanding;
  logic [7:0]  drop_count;

  int errCnt = 0;
  int chkCnt = 0;

  prefetch_queue #(.ADDR_W(16), .DEPTH(8), .MAX_OUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .demand_valid   (demand_valid),
    .demand_addr    (demand_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .full           (full),
    .outstanding    (outstanding),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic enq(input logic [15:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic resp(input int n);
    mem_resp_valid = 1'b1;
    for (int i = 0; i < n; i++) step();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int issues;
    int stable;
    logic [15:0] expAddr;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; demand_valid = 1'b0;
    demand_addr = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #12;
    check("rst_valid", mem_req_valid, 0);
    check("rst_addr",  mem_req_addr, 0);
    check("rst_full",  full, 0);
    check("rst_out",   outstanding, 0);
    check("rst_drop",  drop_count, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Basic issue
    mem_req_ready = 1'b1;
    enq(16'h0040);
    check("basic_valid", mem_req_valid, 1);
    check("basic_addr",  mem_req_addr, 16'h0040);
    step();
    check("basic_out1",  outstanding, 1);
    check("basic_idle",  mem_req_valid, 0);
    resp(1);
    check("basic_out0",  outstanding, 0);

    // Duplicates in queue and in flight
    mem_req_ready = 1'b0;
    enq(16'h0100); enq(16'h0100); enq(16'h0200);
    check("dup_drop1", drop_count, 1);
    check("dup_head",  mem_req_addr, 16'h0100);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    check("dup_out1",  outstanding, 1);
    check("dup_head2", mem_req_addr, 16'h0200);
    enq(16'h0100);
    check("dup_drop2", drop_count, 2);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    check("dup_empty", mem_req_valid, 0);
    check("dup_out2",  outstanding, 2);
    resp(2);
    check("dup_out0",  outstanding, 0);

    // Full and in-flight limit
    doReset();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) enq(16'h1000 + 16'(i * 16));
    check("full_set", full, 1);
    enq(16'h1080);
    check("full_drop", drop_count, 1);
    mem_req_ready = 1'b1;
    issues = 0;
    for (int k = 0; k < 8; k++) begin
      if (mem_req_valid) begin
        expAddr = 16'h1000 + 16'(issues * 16);
        check("lim_addr", mem_req_addr, expAddr);
        issues++;
      end
      step();
    end
    check("lim_issues", issues, 4);
    check("lim_out",    outstanding, 4);
    check("lim_valid",  mem_req_valid, 0);
    check("lim_full",   full, 0);
    for (int k = 0; k < 10; k++) begin
      mem_resp_valid = (k < 4);
      if (mem_req_valid) begin
        expAddr = 16'h1000 + 16'(issues * 16);
        check("rest_addr", mem_req_addr, expAddr);
        issues++;
      end
      step();
    end
    mem_resp_valid = 1'b0;
    check("rest_issues", issues, 8);
    check("rest_out",    outstanding, 4);
    mem_req_ready = 1'b0;
    resp(4);
    check("rest_out0",   outstanding, 0);

    // Demand cancel
    enq(16'h0010); enq(16'h0020);
    check("cxl_head", mem_req_addr, 16'h0010);
    demand_valid = 1'b1; demand_addr = 16'h0010;
    step();
    demand_valid = 1'b0;
    check("cxl_fall", mem_req_valid, 0);
    mem_req_ready = 1'b1;
    step();
    check("cxl_next_v", mem_req_valid, 1);
    check("cxl_next_a", mem_req_addr, 16'h0020);
    step();
    mem_req_ready = 1'b0;
    check("cxl_empty", mem_req_valid, 0);
    check("cxl_out",   outstanding, 1);
    resp(1);

    // Handshake stall
    enq(16'h0300);
    stable = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_req_valid === 1'b1 && mem_req_addr === 16'h0300) stable++;
      step();
    end
    check("stall_stable", stable, 5);
    mem_req_ready = 1'b1;
    check("stall_v", mem_req_valid, 1);
    step();
    mem_req_ready = 1'b0;
    check("stall_out", outstanding, 1);
    check("stall_idle", mem_req_valid, 0);
    resp(1);

    // Invalid marker, demand collision, drop saturation
    enq(16'hFFFF);
    check("inv_drop",  drop_count, 1);
    check("inv_valid", mem_req_valid, 0);
    demand_valid = 1'b1; demand_addr = 16'h0050;
    enq(16'h0050);
    demand_valid = 1'b0;
    check("dmd_drop",  drop_count, 2);
    check("dmd_valid", mem_req_valid, 0);
    enq(16'h0500);
    req_valid = 1'b1; req_addr = 16'h0500;
    for (int k = 0; k < 260; k++) step();
    req_valid = 1'b0;
    check("sat_drop", drop_count, 255);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    resp(1);
    check("sat_out0", outstanding, 0);

    // Reset mid-flight
    for (int i = 0; i < 5; i++) enq(16'h0600 + 16'(i * 16));
    mem_req_ready = 1'b1; step(); step(); mem_req_ready = 1'b0;
    check("mid_out",  outstanding, 2);
    check("mid_addr", mem_req_addr, 16'h0620);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", mem_req_valid, 0);
    check("mid_rst_addr",  mem_req_addr, 0);
    check("mid_rst_full",  full, 0);
    check("mid_rst_out",   outstanding, 0);
    check("mid_rst_drop",  drop_count, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    resp(1);
    check("late_resp_out", outstanding, 0);
    check("late_valid",    mem_req_valid, 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Buffers prefetch requests from the stride prefetcher (`submitMemRequest` / `requestAddress`) and issues them to the memory port under a valid/ready handshake. Drops duplicates and cancels queued prefetches overtaken by demand accesses. Bounds the number of in-flight prefetches. Sits directly downstream of the prefetcher and upstream of the memory arbiter.

## Interface
- `ADDR_W`, 16, address width
- `DEPTH`, 8, queue entries; power of two, ≥2
- `MAX_OUT`, 4, maximum in-flight prefetches; ≥1
- `clk`  in  1  clock; all state on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  prefetch request strobe (prefetcher `submitMemRequest`)
- `req_addr`  in  ADDR_W  prefetch address
- `demand_valid`  in  1  demand access this cycle
- `demand_addr`  in  ADDR_W  demand address
- `mem_req_valid`  out  1  prefetch issue valid
- `mem_req_addr`  out  ADDR_W  issued address
- `mem_req_ready`  in  1  memory accepts the issue
- `mem_resp_valid`  in  1  oldest in-flight prefetch completed; responses return in order
- `full`  out  1  queue holds DEPTH entries
- `outstanding`  out  $clog2(MAX_OUT+1)  in-flight count
- `drop_count`  out  8  saturating count of rejected requests

## Operation
- Reset values: queue empty, in-flight list empty, `mem_req_valid`=0, `mem_req_addr`=0, `full`=0, `outstanding`=0, `drop_count`=0.
- Each queue entry holds `{valid, cancelled, addr}`. The in-flight list is a FIFO of MAX_OUT addresses.
- **Enqueue.** `req_valid` with `req_addr` ≠ all-ones is accepted unless one of the following holds:
  - the queue is full (evaluated on registered state; there is no same-cycle bypass);
  - `req_addr` equals the address of any valid, non-cancelled queue entry;
  - `req_addr` equals any in-flight address;
  - `demand_valid` is high and `demand_addr` == `req_addr`.
- **Drops.** A rejected request increments `drop_count`, which saturates at 255. `req_addr` == all-ones is ignored silently: it is the invalid marker and is not counted as a drop.
- **Cancel.** `demand_valid` sets `cancelled` on every valid queue entry whose address equals `demand_addr`.
- **Head handling.**
  - Cancelled head: popped without issue, one per cycle.
  - Non-cancelled head with `outstanding` < MAX_OUT: drives `mem_req_valid`=1 and `mem_req_addr`=head addr.
  - On `mem_req_valid && mem_req_ready`: pop the head and push its address onto the in-flight list.
  - `mem_req_valid` never drops until accepted. `mem_req_addr` is held stable while valid and not ready.
  - A demand matching the head while `mem_req_valid` is high and `mem_req_ready` is low cancels the head. `mem_req_valid` falls next cycle.
- **Responses.** `mem_resp_valid` pops the oldest in-flight entry. `mem_resp_valid` with `outstanding`==0 is ignored.
- **Simultaneous events.**
  - Issue and response in the same cycle leave `outstanding` unchanged.
  - Enqueue and pop in the same cycle leave the occupancy unchanged.
  - Arithmetic: pointers wrap modulo DEPTH. Occupancy is kept in a $clog2(DEPTH)+1 bit counter.
- **Reset mid-operation.** Asserting `rst_n`=0 clears all state immediately. In-flight requests are forgotten, and late responses after reset are ignored because `outstanding` is 0.

## Timing
- A request accepted at edge N produces `mem_req_valid`=1 in the cycle after N at the earliest (1-cycle latency from an empty queue).
- `mem_req_valid` and `mem_req_addr` are driven combinationally from registered state only. There is no combinational path from `mem_req_ready`, `req_*` or `demand_*` to `mem_req_valid`.
- Throughput: one issue per cycle with `mem_req_ready` high and `outstanding` < MAX_OUT.
- `full`, `outstanding` and `drop_count` reflect the state after the last edge.

## Structure
- Package `pf_pkg` holds:
  - the `ADDR_W` default;
  - `ADDR_INVALID` = all-ones;
  - a packed struct `pf_entry_t {valid, cancelled, addr}`.
- Sub-module `pf_inflight_fifo`: MAX_OUT-deep address FIFO with push, pop, count and a parallel match output for a probe address. The queue itself stays inline because of the cancel and dedup scans.

## Test plan
- **Basic issue.** Reset, then `req` 0x0040 with `mem_req_ready`=1 → `mem_req_valid` the next cycle with addr 0x0040; `outstanding`=1; after `mem_resp_valid`, `outstanding`=0.
- **Duplicates.** Enqueue 0x0100 twice and 0x0200 once while `mem_req_ready`=0 → queue holds 2 entries and `drop_count`=1. Re-request 0x0100 after it issues but before its response → dropped, `drop_count`=2.
- **Full and in-flight limit.** `mem_req_ready`=0, enqueue 9 distinct addresses → `full`=1 after 8 and `drop_count`=1. Then set ready=1 with no responses → exactly 4 issues and `outstanding`=4. Four responses → the remaining 4 issue.
- **Demand cancel.** Queue 0x0010 and 0x0020 with ready=0, demand 0x0010 → on ready=1 only 0x0020 issues, with a 1-cycle skip for the cancelled head.
- **Handshake stall.** Ready held low for 5 cycles → `mem_req_valid` and `mem_req_addr` stay constant. Issue on the first ready cycle.
- **Reset mid-flight.** Reset with 3 queued and 2 in flight → all outputs return to reset values. A following `mem_resp_valid` leaves `outstanding`=0.
